// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int unsigned BCD_DIGITS = 4;
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned BCD_W      = BCD_DIGITS * NIB_W;
  localparam int unsigned BCD_MAX    = 9999;
  localparam logic [3:0]  SAT_DIGIT  = 4'd9;

endpackage

// File: rtl/bcd_nibble_adj.sv
// Double-dabble correction for one BCD nibble: values of 5 or more get +3.
module bcd_nibble_adj
  import bcd_pkg::*;
(
  input  logic [NIB_W-1:0] d,
  output logic [NIB_W-1:0] q_c
);

  always_comb begin
    q_c = d;
    if (d >= NIB_W'(5)) q_c = d + NIB_W'(3);
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one input bit per clock, with a
// valid/ready intake and registered, saturating four-digit output.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int unsigned WIDTH = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] bin,
  output logic [3:0]       num0,
  output logic [3:0]       num1,
  output logic [3:0]       num2,
  output logic [3:0]       num3,
  output logic             out_valid,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned SR_W  = BCD_W + WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  if (WIDTH < 4 || WIDTH > 14) begin : g_width_check
    $error("bin_to_bcd_seq: WIDTH must be within 4..14");
  end

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SR_W-1:0]    sr_q, sr_d;
  logic               ovf_lat_q, ovf_lat_d;
  logic [BCD_W-1:0]   digits_q, digits_d;
  logic               out_valid_q, out_valid_d;
  logic               ovf_q, ovf_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;

  logic [BCD_W-1:0]   bcd_adj_c;
  logic [SR_W-1:0]    sr_shift_c;

  // Per-nibble add-3 correction ahead of each shift.
  for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_adj
    bcd_nibble_adj u_adj (
      .d   (sr_q[WIDTH + NIB_W*i +: NIB_W]),
      .q_c (bcd_adj_c[NIB_W*i +: NIB_W])
    );
  end

  // Carry out of the thousands nibble falls off the top; saturation covers it.
  assign sr_shift_c = SR_W'({bcd_adj_c, sr_q[WIDTH-1:0]} << 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sr_q        <= '0;
      ovf_lat_q   <= 1'b0;
      digits_q    <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      ovf_lat_q   <= ovf_lat_d;
      digits_q    <= digits_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    ovf_lat_d   = ovf_lat_q;
    digits_d    = digits_q;
    out_valid_d = 1'b0;
    ovf_d       = ovf_q;
    ready_d     = ready_q;

    case (state_q)
      IDLE: begin
        if (in_valid && ready_q) begin
          state_d   = SHIFT;
          sr_d      = {BCD_W'(0), bin};
          cnt_d     = CNT_W'(WIDTH);
          ovf_lat_d = (32'(bin) > 32'(BCD_MAX));
          ready_d   = 1'b0;
        end
      end
      SHIFT: begin
        sr_d  = sr_shift_c;
        cnt_d = cnt_q - CNT_W'(1);
        // Last bit: publish digits and return to idle in the same edge.
        if (cnt_q == CNT_W'(1)) begin
          state_d     = IDLE;
          digits_d    = ovf_lat_q ? {BCD_DIGITS{SAT_DIGIT}} : sr_shift_c[SR_W-1 -: BCD_W];
          ovf_d       = ovf_lat_q;
          out_valid_d = 1'b1;
          ready_d     = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase

    busy_d = ~ready_d;
  end

  assign num0      = digits_q[0*NIB_W +: NIB_W];
  assign num1      = digits_q[1*NIB_W +: NIB_W];
  assign num2      = digits_q[2*NIB_W +: NIB_W];
  assign num3      = digits_q[3*NIB_W +: NIB_W];
  assign out_valid = out_valid_q;
  assign ovf       = ovf_q;
  assign in_ready  = ready_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: directed boundaries plus random values at WIDTH 14 and 8.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [13:0] bin = '0;
  logic [3:0]  num0, num1, num2, num3;
  logic        out_valid, ovf, busy;

  logic        in_valid8 = 1'b0;
  logic        in_ready8;
  logic [7:0]  bin8 = '0;
  logic [3:0]  m0, m1, m2, m3;
  logic        out_valid8, ovf8, busy8;

  int total = 0;
  int bad   = 0;

  logic [15:0] dig, dig8;
  assign dig  = {num3, num2, num1, num0};
  assign dig8 = {m3, m2, m1, m0};

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.WIDTH(14)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .bin(bin),
    .num0(num0), .num1(num1), .num2(num2), .num3(num3),
    .out_valid(out_valid), .ovf(ovf), .busy(busy)
  );

  bin_to_bcd_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8), .bin(bin8),
    .num0(m0), .num1(m1), .num2(m2), .num3(m3),
    .out_valid(out_valid8), .ovf(ovf8), .busy(busy8)
  );

  // Reference: decimal digits of the value, clamped to 9999.
  function automatic logic [15:0] model(input int v);
    int s;
    s = (v > 9999) ? 9999 : v;
    return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge right after the acceptance edge.
  task automatic wait_done(input int v, input int lat, input string tag);
    logic [15:0] prev;
    int k;
    prev = dig;
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (out_valid) break;
      chk({tag, "_hold"}, 32'(dig), 32'(prev));
    end
    chk({tag, "_lat"}, 32'(k), 32'(lat));
    chk({tag, "_digits"}, 32'(dig), 32'(model(v)));
    chk({tag, "_ovf"}, 32'(ovf), 32'(v > 9999));
    chk({tag, "_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    @(negedge clk);
    chk({tag, "_pulse_end"}, 32'(out_valid), 32'd0);
    chk({tag, "_digits_hold"}, 32'(dig), 32'(model(v)));
  endtask

  task automatic wait_ready(input string tag);
    for (int i = 0; i < 40 && !in_ready; i++) @(negedge clk);
    chk({tag, "_ready_wait"}, 32'(in_ready), 32'd1);
  endtask

  task automatic conv(input int v, input string tag);
    wait_ready(tag);
    in_valid = 1'b1;
    bin      = 14'(v);
    @(negedge clk);
    in_valid = 1'b0;
    bin      = 14'($urandom);
    wait_done(v, 14, tag);
  endtask

  task automatic conv8(input int v, input string tag);
    int k;
    for (int i = 0; i < 40 && !in_ready8; i++) @(negedge clk);
    in_valid8 = 1'b1;
    bin8      = 8'(v);
    @(negedge clk);
    in_valid8 = 1'b0;
    bin8      = 8'($urandom);
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (out_valid8) break;
    end
    chk({tag, "_lat"}, 32'(k), 32'd8);
    chk({tag, "_digits"}, 32'(dig8), 32'(model(v)));
    chk({tag, "_ovf"}, 32'(ovf8), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int second;
    bit seen;
    logic [15:0] prev;

    // Reset and release
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_digits", 32'(dig), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);

    // Directed values and boundaries
    conv(1234, "c1234");
    conv(0, "c0");
    conv(9999, "c9999");
    conv(10000, "c10000");
    conv(16383, "c16383");

    // in_valid held high, bin scrambled during SHIFT
    wait_ready("held");
    in_valid = 1'b1;
    bin      = 14'd42;
    prev     = dig;
    second   = -1;
    seen     = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (out_valid && !seen) begin
        seen = 1'b1;
        chk("held_lat", 32'(c), 32'd15);
        chk("held_digits", 32'(dig), 32'(model(42)));
      end else if (!seen) begin
        chk("held_hold", 32'(dig), 32'(prev));
      end
      if (in_ready) begin
        second = c;
        break;
      end
      bin = 14'($urandom_range(0, 16383));
    end
    chk("held_seen", 32'(seen), 32'd1);
    chk("held_next_accept", 32'(second), 32'd15);
    bin = 14'd5;
    @(negedge clk);
    in_valid = 1'b0;
    wait_done(5, 14, "held2");

    // Reset mid-conversion
    conv(777, "c0777");
    wait_ready("c5555");
    in_valid = 1'b1;
    bin      = 14'd5555;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_digits", 32'(dig), 32'd0);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_pulse", 32'(seen), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    conv(321, "c0321");

    // Random values against the model
    for (int i = 0; i < 20; i++) begin
      conv(int'($urandom_range(0, 16383)), "rand");
    end

    // Narrow build
    conv8(255, "w8_255");
    for (int i = 0; i < 6; i++) begin
      conv8(int'($urandom_range(0, 255)), "w8_rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Sequential binary-to-BCD converter using shift-and-add-3 (double-dabble), one bit per clock. It sits directly upstream of the four-digit multiplexed seven-segment driver. It turns a binary count (0–9999) into four registered BCD digits that connect straight to that driver's `num0`..`num3` inputs. A valid/ready handshake accepts one value at a time, and the digit outputs hold steady between conversions so the display never flickers mid-update.

## Interface
Parameters:
- `WIDTH`, default 14: binary input width. Legal range is 4..14; elaboration fails outside it.

Ports:
- Clocking: one clock; reset is asynchronous and active-low.
- `clk` input 1: system clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `in_valid` input 1: `bin` holds a value to convert.
- `in_ready` output 1: the converter is idle and can accept a value.
- `bin` input WIDTH: unsigned binary value, sampled only on the acceptance edge.
- `num0` output 4: BCD ones digit (registered).
- `num1` output 4: BCD tens digit.
- `num2` output 4: BCD hundreds digit.
- `num3` output 4: BCD thousands digit.
- `out_valid` output 1: one-cycle pulse when new digits appear on `num0`..`num3`.
- `ovf` output 1: the last accepted value exceeded 9999; digits are saturated. Held until the next completion.
- `busy` output 1: equals `~in_ready`.

## Operation
- FSM states: IDLE and SHIFT.
- IDLE:
  - `in_ready` = 1.
  - On an edge with `in_valid && in_ready`, the block accepts the value:
    - load the shift register as {16'b0 BCD field, `bin`};
    - load the bit counter with WIDTH;
    - latch the overflow flag as (`bin` > 9999);
    - go to SHIFT.
- SHIFT, one edge per input bit:
  - Add 3 to every BCD nibble ≥ 5 (combinationally).
  - Shift the whole {BCD, binary} register left by 1.
  - Decrement the counter.
- Final SHIFT edge (counter == 1):
  - Write the corrected and shifted BCD field into `num3`..`num0`.
  - If the latched overflow flag is set, write 9,9,9,9 instead.
  - Set `ovf` to the latched flag and `out_valid` = 1.
  - Go to IDLE.
- `out_valid` clears on the following edge.
- `in_valid` during SHIFT is ignored. `bin` may change freely during SHIFT without effect.
- Digits are always 0..9, never A–F, so the downstream hex decoder shows decimal only.
- Thousands-digit carry-out above 9 is discarded; saturation covers every such input.

## Timing
- Reset values (asynchronous):
  - state = IDLE;
  - `num0`..`num3` = 0, `out_valid` = 0, `ovf` = 0;
  - `in_ready` = 1 and `busy` = 0 from the first cycle after reset is released.
- Latency: the acceptance edge is T0. Shift edges are T1..T_WIDTH. New digits and `out_valid` are visible in the cycle after T_WIDTH, which is 14 cycles at the default.
- `in_ready` returns to 1 in the same cycle that `out_valid` is high.
- Throughput with `in_valid` held high: one conversion per WIDTH+1 cycles (15 at the default).
- Digit outputs change only on the completion edge. They hold their previous value throughout SHIFT.
- Reset asserted mid-conversion:
  - conversion aborts immediately;
  - outputs return to their reset values;
  - no `out_valid` pulse occurs.
- `in_valid` deasserted in IDLE: nothing happens and the outputs hold.

## Structure
- Shared package `bcd_pkg`:
  - state typedef (IDLE, SHIFT);
  - `BCD_DIGITS` = 4;
  - `BCD_MAX` = 9999;
  - `SAT_DIGIT` = 4'd9.
- One natural sub-module: `bcd_nibble_adj`, a combinational nibble function (≥5 → +3, else pass-through). Instantiate it four times on the BCD field ahead of the shift.
- Top-level contents:
  - FSM;
  - counter (width $clog2(WIDTH+1));
  - (16+WIDTH)-bit shift register;
  - overflow flag;
  - output registers.

## Test plan
- Reset, then release: `num0`..`num3` = 0, `out_valid` = 0, `ovf` = 0, `in_ready` = 1, `busy` = 0.
- `bin` = 1234 with a one-cycle `in_valid`: exactly 14 cycles later, `out_valid` pulses once with `num3`..`num0` = 1,2,3,4 and `ovf` = 0; `in_ready` is high in that same cycle.
- Boundaries:
  - `bin` = 0 → 0,0,0,0;
  - `bin` = 9999 → 9,9,9,9 with `ovf` = 0;
  - `bin` = 10000 → 9,9,9,9 with `ovf` = 1;
  - `bin` = 16383 → 9,9,9,9 with `ovf` = 1.
- Hold `in_valid` = 1 while changing `bin` every cycle during SHIFT (start with 0042):
  - the result is 0,0,4,2;
  - the next acceptance occurs 15 cycles after the first;
  - digits never change between `out_valid` pulses.
- Convert 0777 → 0,7,7,7. Then assert `rst_n` = 0 at cycle 7 of a 5555 conversion:
  - outputs go to 0 immediately;
  - no `out_valid` occurs;
  - after release, `in_ready` = 1 and a new 0321 conversion gives 0,3,2,1.
- WIDTH = 8 build: `bin` = 255 → 0,2,5,5 with `out_valid` 8 cycles after acceptance.
